// File: rtl/slink_apb_reg_bridge_if.sv
// APB completer + register-bus signal bundle for slink_apb_reg_bridge.
// slave = bridge view, master = requester/register-block view.
interface slink_apb_reg_bridge_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] apb_paddr;
  logic                  apb_pwrite;
  logic                  apb_psel;
  logic                  apb_penable;
  logic [31:0]           apb_pwdata;
  logic [31:0]           apb_prdata;
  logic                  apb_pready;
  logic                  apb_pslverr;

  logic                  reg_req;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_wdata;
  logic                  reg_ack;
  logic [31:0]           reg_rdata;
  logic                  reg_err;

  modport slave (
    input  apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr,
    output reg_req, reg_write, reg_addr, reg_wdata,
    input  reg_ack, reg_rdata, reg_err
  );

  modport master (
    output apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr,
    input  reg_req, reg_write, reg_addr, reg_wdata,
    output reg_ack, reg_rdata, reg_err
  );
endinterface

// File: rtl/slink_apb_reg_bridge.sv
// APB completer bridging each transfer to one req/ack register access.
// Optional access timeout compiled in with `define SLINK_APB_TIMEOUT_EN.
module slink_apb_reg_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     apb_clk,
  input  logic                     apb_reset,
  slink_apb_reg_bridge_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_req_nxt;
  logic                  w_write_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [31:0]           w_wdata_nxt;
  logic                  w_pready_nxt;
  logic                  w_pslverr_nxt;
  logic [31:0]           w_prdata_nxt;
  logic                  w_timeout;

`ifdef SLINK_APB_TIMEOUT_EN
  // Cleared outside REQ, so it holds k-1 in the k-th cycle of reg_req.
  logic [7:0] r_cnt;

  always_ff @(posedge apb_clk) begin
    if (apb_reset || r_state != S_REQ) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = bus.reg_req;
    w_write_nxt   = bus.reg_write;
    w_addr_nxt    = bus.reg_addr;
    w_wdata_nxt   = bus.reg_wdata;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.apb_psel && !bus.apb_penable) begin
          w_addr_nxt  = bus.apb_paddr;
          w_write_nxt = bus.apb_pwrite;
          w_wdata_nxt = bus.apb_pwdata;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Abort outranks ack, and ack outranks timeout in the same cycle.
        if (!bus.apb_psel) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (bus.reg_ack) begin
          w_req_nxt     = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = bus.reg_err;
          w_prdata_nxt  = bus.reg_write ? '0 : bus.reg_rdata;
          w_state_nxt   = S_DONE;
        end else if (w_timeout) begin
          w_req_nxt     = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      r_state         <= S_IDLE;
      bus.reg_req     <= 1'b0;
      bus.reg_write   <= 1'b0;
      bus.reg_addr    <= '0;
      bus.reg_wdata   <= '0;
      bus.apb_pready  <= 1'b0;
      bus.apb_pslverr <= 1'b0;
      bus.apb_prdata  <= '0;
    end else begin
      r_state         <= w_state_nxt;
      bus.reg_req     <= w_req_nxt;
      bus.reg_write   <= w_write_nxt;
      bus.reg_addr    <= w_addr_nxt;
      bus.reg_wdata   <= w_wdata_nxt;
      bus.apb_pready  <= w_pready_nxt;
      bus.apb_pslverr <= w_pslverr_nxt;
      bus.apb_prdata  <= w_prdata_nxt;
    end
  end

endmodule

// File: tb/tb_slink_apb_reg_bridge.sv
// Randomized self-checking bench for slink_apb_reg_bridge.
// Honours `define SLINK_APB_TIMEOUT_EN when the RTL is built with it.
module tb_slink_apb_reg_bridge;

  localparam int AW = 8;
  localparam int TO = 16;
`ifdef SLINK_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic apb_clk = 1'b0;
  logic apb_reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   xid      = 0;

  always #5 apb_clk = ~apb_clk;

  slink_apb_reg_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  slink_apb_reg_bridge #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .apb_clk  (apb_clk),
    .apb_reset(apb_reset),
    .bus      (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.apb_psel    = 1'b0;
    bus.apb_penable = 1'b0;
    bus.reg_ack     = 1'b0;
    bus.reg_err     = 1'b0;
    bus.reg_rdata   = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".req"},    32'(bus.reg_req),     32'd0);
    check_eq({tag, ".pready"}, 32'(bus.apb_pready),  32'd0);
    check_eq({tag, ".slverr"}, 32'(bus.apb_pslverr), 32'd0);
    check_eq({tag, ".prdata"}, bus.apb_prdata,       32'd0);
  endtask

  // lat: cycle Tk in which reg_ack is raised (0 = never).
  // abort: cycle in which psel is dropped (0 = never).
  // b2b: requester re-presents a SETUP during the completion cycle.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                      input int lat, input int abort, input logic [31:0] rd,
                      input logic er, input logic b2b);
    int          req_last;
    bit          completes;
    bit          timed_out;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       tg;

    xid++;
    req_last  = (lat == 0) ? 1000 : lat;
    timed_out = 1'b0;
    if (TO_EN && (lat == 0 || lat > TO)) begin
      req_last  = TO;
      timed_out = 1'b1;
    end
    completes = 1'b1;
    if (abort != 0 && abort <= req_last) begin
      req_last  = abort;
      completes = 1'b0;
    end
    exp_err   = timed_out ? 1'b1 : er;
    exp_rdata = (timed_out || wr) ? 32'd0 : rd;

    bus.apb_psel    = 1'b1;
    bus.apb_penable = 1'b0;
    bus.apb_paddr   = addr;
    bus.apb_pwrite  = wr;
    bus.apb_pwdata  = wd;
    bus.reg_ack     = 1'b0;

    for (int t = 1; t <= req_last + 2; t++) begin
      @(negedge apb_clk);
      tg = $sformatf("x%0d.T%0d", xid, t);
      check_eq({tg, ".req"}, 32'(bus.reg_req), 32'(t <= req_last));
      if (t <= req_last) begin
        check_eq({tg, ".addr"},  32'(bus.reg_addr),  32'(addr));
        check_eq({tg, ".write"}, 32'(bus.reg_write), 32'(wr));
        check_eq({tg, ".wdata"}, bus.reg_wdata,      wd);
      end
      if (completes && t == req_last + 1) begin
        check_eq({tg, ".pready"}, 32'(bus.apb_pready),  32'd1);
        check_eq({tg, ".slverr"}, 32'(bus.apb_pslverr), 32'(exp_err));
        check_eq({tg, ".prdata"}, bus.apb_prdata,       exp_rdata);
      end else begin
        check_eq({tg, ".pready"}, 32'(bus.apb_pready),  32'd0);
        check_eq({tg, ".slverr"}, 32'(bus.apb_pslverr), 32'd0);
        check_eq({tg, ".prdata"}, bus.apb_prdata,       32'd0);
      end

      if (t <= req_last) begin
        bus.apb_psel    = !(abort != 0 && t >= abort);
        bus.apb_penable = 1'b1;
        bus.reg_ack     = (t == lat);
        bus.reg_rdata   = (t == lat) ? rd : $urandom;
        bus.reg_err     = (t == lat) ? er : 1'($urandom);
      end else if (t == req_last + 1) begin
        bus.apb_psel    = completes && b2b;
        bus.apb_penable = 1'b0;
        bus.reg_ack     = 1'($urandom);
        bus.reg_rdata   = $urandom;
        bus.reg_err     = 1'($urandom);
      end else begin
        drive_idle();
      end
    end
  endtask

  task automatic reset_mid_read();
    xid++;
    bus.apb_psel    = 1'b1;
    bus.apb_penable = 1'b0;
    bus.apb_paddr   = 8'h10;
    bus.apb_pwrite  = 1'b0;
    bus.apb_pwdata  = $urandom;
    @(negedge apb_clk);
    check_eq("rst.T1.req", 32'(bus.reg_req), 32'd1);
    bus.apb_penable = 1'b1;
    @(negedge apb_clk);
    check_eq("rst.T2.req", 32'(bus.reg_req), 32'd1);
    apb_reset = 1'b1;
    @(negedge apb_clk);
    check_quiet("rst.T3");
    check_eq("rst.T3.addr", 32'(bus.reg_addr), 32'd0);
    apb_reset     = 1'b0;
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'hDEADBEEF;
    for (int t = 4; t <= 7; t++) begin
      @(negedge apb_clk);
      check_quiet($sformatf("rst.T%0d", t));
    end
    drive_idle();
    @(negedge apb_clk);
  endtask

  initial begin
    int lat;
    int abort;

    apb_reset      = 1'b1;
    bus.apb_paddr  = '0;
    bus.apb_pwrite = 1'b0;
    bus.apb_pwdata = '0;
    drive_idle();
    repeat (3) @(negedge apb_clk);
    check_quiet("reset");
    check_eq("reset.addr",  32'(bus.reg_addr),  32'd0);
    check_eq("reset.wdata", bus.reg_wdata,      32'd0);
    check_eq("reset.write", 32'(bus.reg_write), 32'd0);
    apb_reset = 1'b0;
    @(negedge apb_clk);

    xfer(1'b1, 8'h20, 32'h12345678, 1, 0, 32'h55AA55AA, 1'b0, 1'b0);
    xfer(1'b0, 8'h04, 32'h0,        5, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0,        2, 0, 32'h0BADF00D, 1'b1, 1'b0);
    xfer(1'b1, 8'h30, 32'hA5A5A5A5, 3, 0, 32'h0,        1'b1, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0,        8, 3, 32'h11111111, 1'b0, 1'b0);
    xfer(1'b0, 8'h0D, 32'h0,        4, 4, 32'h22222222, 1'b0, 1'b0);
    xfer(1'b0, 8'h40, 32'h0,        1, 0, 32'h33333333, 1'b0, 1'b1);
    xfer(1'b0, 8'h44, 32'h0,       TO, 0, 32'h44444444, 1'b0, 1'b0);
    xfer(1'b1, 8'h48, 32'h66666666, TO + 4, 0, 32'h0,   1'b0, 1'b0);
    if (TO_EN) begin
      xfer(1'b0, 8'h4C, 32'h0, 0, 0, 32'h77777777, 1'b0, 1'b0);
    end
    reset_mid_read();

    for (int i = 0; i < 60; i++) begin
      lat   = $urandom_range(1, 20);
      if (TO_EN && $urandom_range(0, 7) == 0) lat = 0;
      abort = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 22) : 0;
      xfer(1'($urandom), AW'($urandom), $urandom, lat, abort, $urandom,
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slink_apb_reg_bridge.md
# slink_apb_reg_bridge

APB completer that sits directly downstream of the S-Link APB requester and converts each APB transfer into a single request/acknowledge access on a simple register bus. Register blocks respond with variable latency. The bridge handles wait states, returns read data, and maps register-side errors onto `apb_pslverr`. An optional timeout terminates accesses whose register target never acknowledges.

## Interface
- `ADDR_WIDTH`, 8: width of `apb_paddr` and `reg_addr`.
- `TIMEOUT_CYCLES`, 16: maximum number of cycles `reg_req` stays high before the access is aborted (used only with timeout compiled in). Legal range 1..255.
- `apb_clk`  in  1  single clock; all logic on its rising edge.
- `apb_reset`  in  1  reset, synchronous, active-high.
- `apb_paddr`  in  ADDR_WIDTH  APB address.
- `apb_pwrite`  in  1  1 = write, 0 = read.
- `apb_psel`  in  1  APB select.
- `apb_penable`  in  1  APB access phase.
- `apb_pwdata`  in  32  APB write data.
- `apb_prdata`  out  32  read data, valid when `apb_pready` = 1.
- `apb_pready`  out  1  transfer complete.
- `apb_pslverr`  out  1  transfer error, valid when `apb_pready` = 1.
- `reg_req`  out  1  register access request.
- `reg_write`  out  1  access direction; stable while `reg_req` is high.
- `reg_addr`  out  ADDR_WIDTH  access address; stable while `reg_req` is high.
- `reg_wdata`  out  32  write data; stable while `reg_req` is high.
- `reg_ack`  in  1  access complete; sampled only while `reg_req` is high.
- `reg_rdata`  in  32  read data; sampled in the `reg_ack` cycle.
- `reg_err`  in  1  access error; sampled in the `reg_ack` cycle.

## Operation
- All outputs are registered. On reset, every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - A SETUP phase (`apb_psel`=1, `apb_penable`=0) captures `apb_paddr`, `apb_pwrite` and `apb_pwdata` into `reg_addr`, `reg_write` and `reg_wdata`.
  - Next state is REQ, with `reg_req`=1 and the timeout counter cleared.
- **REQ**
  - `reg_req` is held high and the counter increments each cycle.
  - On `reg_ack`=1:
    - `reg_req` goes to 0 next cycle.
    - `apb_prdata` is set to `reg_rdata` for a read, or 0 for a write.
    - `apb_pslverr` is set to `reg_err`.
    - `apb_pready` goes to 1.
    - Next state is DONE.
- **DONE**
  - `apb_pready` is high for exactly one cycle.
  - `apb_pready`, `apb_pslverr` and `apb_prdata` all return to 0 next cycle, and the FSM returns to IDLE.
- **Protocol abort**
  - If `apb_psel` falls while in REQ, `reg_req` drops next cycle, no `apb_pready` is produced, and the FSM returns to IDLE.
  - A `reg_ack` in that same cycle is ignored.
- **Back-to-back transfers:** a new SETUP in the DONE cycle is ignored. SETUP is accepted only in IDLE, so the requester must re-issue it.
- **Reset mid-access:** the FSM returns to IDLE and all outputs are 0 at the next edge. A late `reg_ack` is ignored.

## Timing
- Cycle T0: SETUP phase.
- Cycle T1: `reg_req`=1 and APB ACCESS phase (`apb_penable`=1).
- `reg_ack` in cycle Tk (k ≥ 1) produces `apb_pready`=1 in Tk+1.
- Minimum transfer is 3 cycles (T0..T2), i.e. one APB wait state.
- `reg_req` is high for exactly k cycles: T1..Tk.
- There is never more than one outstanding register access.

## Configuration
- `SLINK_APB_TIMEOUT_EN` defined:
  - If `reg_ack` is still 0 in the `TIMEOUT_CYCLES`-th cycle of `reg_req`, `reg_req` drops next cycle.
  - In that same cycle `apb_pready`=1, `apb_pslverr`=1 and `apb_prdata`=0; the FSM then goes to DONE.
  - A `reg_ack` in exactly the `TIMEOUT_CYCLES`-th cycle wins over the timeout and completes normally.
- `SLINK_APB_TIMEOUT_EN` undefined:
  - No counter is built; REQ waits indefinitely.
  - `apb_pslverr` comes only from `reg_err`.

## Test plan
- **Write, zero-latency ack:** write 0x12345678 to 0x20 with `reg_ack` asserted in T1 → `reg_req` high only in T1, `reg_addr`=0x20, `reg_wdata`=0x12345678, `reg_write`=1; `apb_pready`=1 in T2, `apb_pslverr`=0, `apb_prdata`=0.
- **Read, 5-cycle latency:** read 0x04 with ack in T5 and `reg_rdata`=0xCAFEF00D → `apb_pready`=1 only in T6, `apb_prdata`=0xCAFEF00D.
- **Read error:** read 0x08 with ack and `reg_err`=1 in T2 → `apb_pready`=1 and `apb_pslverr`=1 in T3, then all outputs 0 in T4.
- **Timeout** (`SLINK_APB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):
  - No ack → `reg_req` high T1..T16; in T17 `apb_pready`=1, `apb_pslverr`=1, `apb_prdata`=0.
  - Ack in T16 → normal completion in T17 with `apb_pslverr`=0.
- **Abort and reset:**
  - `apb_psel` dropped in T3 while waiting → `reg_req`=0 in T4, no `apb_pready`.
  - `apb_reset` asserted in T2 of a pending read → all outputs 0 in T3; a later `reg_ack` produces no `apb_pready`.
